// File: rtl/acc_ctrl_pkg.sv
// Shared MMU definitions: accumulation sequencer state encoding and the
// default array geometry common to the accumulator and systolic array.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ACCUM,
    ACC_DRAIN,
    ACC_DONE
  } acc_state_e;

  localparam int MMU_PE_SIZE    = 16;
  localparam int MMU_FIFO_DEPTH = 16;
  localparam int ACC_TILE_W     = 8;

endpackage

// File: rtl/acc_col_cnt.sv
// Per-column psum write tracker: row counter, K-tile counter, completion flag
// and a strobe-after-completion error indication.
module acc_col_cnt
  import acc_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = MMU_FIFO_DEPTH,
  parameter int TILE_W     = ACC_TILE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              cnt_en_i,
  input  logic              psum_en_i,
  input  logic [TILE_W-1:0] tile_num_i,
  output logic              complete_o,
  output logic              err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(FIFO_DEPTH - 1);

  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
  logic              complete_q, complete_d;
  logic              col_done;

  // A clear on job start overrides any stale completion from the previous job.
  assign col_done = complete_q && !clr_i;

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    tile_cnt_d = tile_cnt_q;
    if (clr_i) begin
      wr_cnt_d   = '0;
      tile_cnt_d = '0;
    end
    if (cnt_en_i && psum_en_i) begin
      if (wr_cnt_d == LAST_ROW) begin
        wr_cnt_d = '0;
        if (!col_done) tile_cnt_d = tile_cnt_d + TILE_W'(1);
      end else begin
        wr_cnt_d = wr_cnt_d + CW'(1);
      end
    end
    complete_d = (tile_cnt_d == tile_num_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q   <= '0;
      tile_cnt_q <= '0;
      complete_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      complete_q <= complete_d;
    end
  end

  // Lookahead completion lets the sequencer leave ACCUM right after the final strobe.
  assign complete_o = complete_d;
  assign err_o      = cnt_en_i && psum_en_i && col_done;

endmodule

// File: rtl/acc_ctrl.sv
// MMU accumulation sequencer: tracks per-column psum writes across K-tiles,
// then drains the accumulated rows to the GLB under a ready handshake.
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int PE_SIZE    = MMU_PE_SIZE,
  parameter int FIFO_DEPTH = MMU_FIFO_DEPTH,
  parameter int TILE_W     = ACC_TILE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [TILE_W-1:0]             tile_num_i,
  input  logic [PE_SIZE-1:0]            psum_en_i,
  input  logic                          glb_ready_i,
  output logic [PE_SIZE-1:0]            rden_o,
  output logic                          glb_wen_o,
  output logic [$clog2(FIFO_DEPTH)-1:0] glb_addr_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] RD_END = CW'(FIFO_DEPTH);

  acc_state_e        state_q, state_d;
  logic [TILE_W-1:0] tile_num_q, tile_num_d, tile_num_eff;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              wen_q, wen_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              err_q, err_d;
  logic              accept, cnt_en, rd_fire;
  logic [PE_SIZE-1:0] col_complete, col_err;

  assign accept       = (state_q == ACC_IDLE) && start_i && (tile_num_i != '0);
  assign cnt_en       = (state_q == ACC_ACCUM) || accept;
  assign tile_num_eff = accept ? tile_num_i : tile_num_q;

  for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
    acc_col_cnt #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TILE_W     (TILE_W)
    ) u_col (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (accept),
      .cnt_en_i   (cnt_en),
      .psum_en_i  (psum_en_i[c]),
      .tile_num_i (tile_num_eff),
      .complete_o (col_complete[c]),
      .err_o      (col_err[c])
    );
  end

  always_comb begin
    state_d    = state_q;
    tile_num_d = tile_num_q;
    rd_cnt_d   = rd_cnt_q;
    rd_fire    = 1'b0;
    case (state_q)
      ACC_IDLE: begin
        if (accept) begin
          state_d    = ACC_ACCUM;
          tile_num_d = tile_num_i;
          rd_cnt_d   = '0;
        end
      end
      ACC_ACCUM: begin
        if (&col_complete) state_d = ACC_DRAIN;
      end
      ACC_DRAIN: begin
        // Terminal count means the last read was issued last cycle and its write is on the bus now.
        if (rd_cnt_q == RD_END) begin
          state_d = ACC_DONE;
        end else if (glb_ready_i) begin
          rd_fire  = 1'b1;
          rd_cnt_d = rd_cnt_q + CW'(1);
        end
      end
      ACC_DONE: state_d = ACC_IDLE;
      default:  state_d = ACC_IDLE;
    endcase

    wen_d  = rd_fire;
    addr_d = rd_fire ? rd_cnt_q[AW-1:0] : addr_q;

    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((|col_err) || ((|psum_en_i) && (state_q != ACC_ACCUM))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACC_IDLE;
      tile_num_q <= '0;
      rd_cnt_q   <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_num_q <= tile_num_d;
      rd_cnt_q   <= rd_cnt_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
    end
  end

  assign rden_o     = {PE_SIZE{rd_fire}};
  assign glb_wen_o  = wen_q;
  assign glb_addr_o = addr_q;
  assign busy_o     = (state_q != ACC_IDLE);
  assign done_o     = (state_q == ACC_DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl: job-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed latencies and addresses.
module tb_acc_ctrl;

  localparam int PE = 4;
  localparam int FD = 4;
  localparam int TW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [TW-1:0] tile_num_i = '0;
  logic [PE-1:0] psum_en_i = '0;
  logic          glb_ready_i = 1'b0;
  logic [PE-1:0] rden_o;
  logic          glb_wen_o;
  logic [AW-1:0] glb_addr_o;
  logic          busy_o, done_o, err_o;

  acc_ctrl #(.PE_SIZE(PE), .FIFO_DEPTH(FD), .TILE_W(TW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .tile_num_i  (tile_num_i),
    .psum_en_i   (psum_en_i),
    .glb_ready_i (glb_ready_i),
    .rden_o      (rden_o),
    .glb_wen_o   (glb_wen_o),
    .glb_addr_o  (glb_addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Job-level model: phase 0..3 = idle/accum/drain/done, writes tracked as
  // per-column totals, a column is complete once it has tiles*FD writes.
  int m_phase = 0, m_tiles = 0, m_reads = 0, m_addr = 0;
  int m_cnt[PE];
  bit m_wen = 1'b0, m_err = 1'b0;

  function automatic bit m_rden();
    return (m_phase == 2) && glb_ready_i && (m_reads < FD);
  endfunction

  function automatic bit m_col_hit();
    bit h = 1'b0;
    for (int c = 0; c < PE; c++)
      if (psum_en_i[c] && (m_cnt[c] >= m_tiles * FD)) h = 1'b1;
    return h;
  endfunction

  function automatic bit m_all_done();
    bit a = 1'b1;
    for (int c = 0; c < PE; c++)
      if (m_cnt[c] + int'(psum_en_i[c]) < m_tiles * FD) a = 1'b0;
    return a;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_tiles <= 0; m_reads <= 0; m_addr <= 0;
      m_wen <= 1'b0; m_err <= 1'b0;
      for (int c = 0; c < PE; c++) m_cnt[c] <= 0;
    end else begin
      m_wen <= m_rden();
      if (m_rden()) begin
        m_addr  <= m_reads;
        m_reads <= m_reads + 1;
      end
      if (m_phase == 0 && start_i && tile_num_i != 0) m_err <= 1'b0;
      else if (psum_en_i != 0 && m_phase != 1)        m_err <= 1'b1;
      else if (m_phase == 1 && m_col_hit())           m_err <= 1'b1;
      case (m_phase)
        0: if (start_i && tile_num_i != 0) begin
             m_phase <= 1;
             m_tiles <= int'(tile_num_i);
             m_reads <= 0;
             for (int c = 0; c < PE; c++) m_cnt[c] <= int'(psum_en_i[c]);
           end
        1: begin
             for (int c = 0; c < PE; c++) m_cnt[c] <= m_cnt[c] + int'(psum_en_i[c]);
             if (m_all_done()) m_phase <= 2;
           end
        2: if (m_reads == FD) m_phase <= 3;
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", 32'(busy_o), 32'(m_phase != 0));
      chk("cyc_done", 32'(done_o), 32'(m_phase == 3));
      chk("cyc_rden", 32'(rden_o), 32'({PE{m_rden()}}));
      chk("cyc_wen",  32'(glb_wen_o), 32'(m_wen));
      if (m_wen) chk("cyc_addr", 32'(glb_addr_o), 32'(m_addr));
      chk("cyc_err",  32'(err_o), 32'(m_err));
    end
  end

  int cyc = 0;
  int rden_cnt = 0, done_cnt = 0, first_rden = -1, done_cyc = -1, last_cyc = 0;
  int addrq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rden_o != '0) begin
      if (rden_cnt == 0) first_rden = cyc;
      rden_cnt++;
    end
    if (glb_wen_o) addrq.push_back(int'(glb_addr_o));
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clr_mon();
    rden_cnt = 0; done_cnt = 0; first_rden = -1; done_cyc = -1;
    addrq.delete();
  endtask

  task automatic step(input logic s, input logic [TW-1:0] t, input logic [PE-1:0] p, input logic r);
    @(posedge clk);
    #1;
    start_i = s; tile_num_i = t; psum_en_i = p; glb_ready_i = r;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
  task automatic wait_done(input int mode, input string nm);
    bit seen = 1'b0;
    for (int j = 0; j < 60 && !seen; j++) begin
      step(1'b0, '0, '0, (mode == 0) ? 1'b1 : (j % 3 == 0));
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    chk({nm, "_done_reached"}, 32'(seen), 32'd1);
    step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk_addrs(input string nm);
    chk({nm, "_wen_count"}, addrq.size(), FD);
    for (int i = 0; i < addrq.size() && i < FD; i++)
      chk($sformatf("%s_addr%0d", nm, i), addrq[i], i);
  endtask

  task automatic basic_job(input string nm, input int mode, input int exp_lat);
    clr_mon();
    step(1'b1, 8'd1, '0, 1'b0);
    @(negedge clk);
    chk({nm, "_busy_on_start_cycle"}, 32'(busy_o), 32'd0);
    for (int i = 0; i < FD; i++) begin
      step(1'b0, '0, '1, 1'b0);
      if (i == 0) begin
        @(negedge clk);
        chk({nm, "_busy_after_start"}, 32'(busy_o), 32'd1);
      end
    end
    last_cyc = cyc;
    wait_done(mode, nm);
    chk({nm, "_latency"}, done_cyc - last_cyc, exp_lat);
    chk({nm, "_first_read"}, first_rden - last_cyc, 1);
    chk({nm, "_reads"}, rden_cnt, FD);
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk_addrs(nm);
  endtask

  initial begin
    logic [PE-1:0] p;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err",  32'(err_o), 0);
    chk("rst_wen",  32'(glb_wen_o), 0);
    chk("rst_rden", 32'(rden_o), 0);
    rst = 1'b0;

    // single tile, ready high: 1 + 4 reads + 1 write + done at last+6
    basic_job("single", 0, 6);

    // skewed three-tile job: column c lags by c cycles
    clr_mon();
    step(1'b1, 8'd3, '0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      for (int c = 0; c < PE; c++) p[c] = (i >= c) && (i < c + 3 * FD);
      step(1'b0, '0, p, 1'b1);
    end
    last_cyc = cyc;
    wait_done(0, "skew");
    chk("skew_first_read", first_rden - last_cyc, 1);
    chk("skew_reads", rden_cnt, FD);
    chk("skew_latency", done_cyc - last_cyc, 6);
    chk("skew_err", 32'(err_o), 0);
    chk_addrs("skew");

    // backpressure 1,0,0: reads at last+1,+4,+7,+10, done at last+12
    basic_job("bp", 1, 12);

    // protocol errors: extra strobe on completed column 0, start during drain
    clr_mon();
    step(1'b1, 8'd1, '0, 1'b0);
    for (int i = 0; i <= FD; i++) begin
      p = '0;
      p[0] = 1'b1;
      for (int c = 1; c < PE; c++) p[c] = (i >= 1);
      step(1'b0, '0, p, 1'b0);
    end
    step(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("perr_err_set", 32'(err_o), 1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 8'd5, '0, 1'b1);
    wait_done(0, "perr");
    chk("perr_reads", rden_cnt, FD);
    chk("perr_done_pulses", done_cnt, 1);
    chk_addrs("perr");
    @(negedge clk);
    chk("perr_err_held", 32'(err_o), 1);
    clr_mon();
    step(1'b1, 8'd1, '0, 1'b0);
    step(1'b0, '0, '1, 1'b0);
    @(negedge clk);
    chk("perr_err_cleared", 32'(err_o), 0);
    for (int i = 1; i < FD; i++) step(1'b0, '0, '1, 1'b0);
    wait_done(0, "perr_clean");
    chk("perr_clean_reads", rden_cnt, FD);

    // zero tiles is ignored
    step(1'b1, 8'd0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    chk("zero_busy", 32'(busy_o), 0);

    // asynchronous reset mid-drain after two reads
    clr_mon();
    step(1'b1, 8'd1, '0, 1'b0);
    for (int i = 0; i < FD; i++) step(1'b0, '0, '1, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    #3;
    chk("rstmid_reads_before", rden_cnt, 2);
    chk("rstmid_wen_before", 32'(glb_wen_o), 1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(busy_o), 0);
    chk("rstmid_wen",  32'(glb_wen_o), 0);
    chk("rstmid_rden", 32'(rden_o), 0);
    chk("rstmid_addr", 32'(glb_addr_o), 0);
    chk("rstmid_done", 32'(done_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    basic_job("after_rst", 0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
